// File: rtl/spi_pixel_rx.sv
// spi_pixel_rx: SPI mode-0 slave that decodes a command byte and emits RGB565 pixel write pulses
module spi_pixel_rx #(
    parameter int          FRAME_PIXELS = 130560,
    parameter logic [7:0]  CMD_FRAME    = 8'h01,
    parameter logic [7:0]  CMD_CONT     = 8'h02
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_spi_clk,
    input  logic        i_spi_cs,
    input  logic        i_spi_mosi,
    output logic [15:0] o_pixel_data,
    output logic        o_pixel_en_pls,
    output logic        o_vsync_pls,
    output logic [16:0] o_pixel_cnt,
    output logic        o_overrun,
    output logic        o_busy
);
    typedef enum logic [1:0] {S_IDLE, S_CMD, S_PIX, S_DISCARD} state_t;
    localparam logic [16:0] LP_MAX = 17'(FRAME_PIXELS);
    state_t      r_state, w_nxt_state;
    logic        r_sck_s1, r_sck_s2, r_sck_s3;
    logic        r_cs_s1, r_cs_s2, r_cs_s3;
    logic        r_mosi_s1, r_mosi_s2;
    logic [1:0]  r_sync_vld;
    logic        r_cs_block;
    logic [15:0] r_shift;
    logic [3:0]  r_bit_cnt;
    logic [15:0] r_pixel_data;
    logic        r_pixel_en, r_vsync, r_overrun;
    logic [16:0] r_pixel_cnt;
    logic        w_sck_rise, w_cs_fall, w_cs_rise, w_shift_en, w_cmd_done, w_pix_done;
    logic [15:0] w_word;
    logic [7:0]  w_byte;
    assign w_sck_rise = r_sck_s2 & ~r_sck_s3;
    // A CS fall seen while still blocked belongs to a transaction that was cut by reset
    assign w_cs_fall  = ~r_cs_s2 & r_cs_s3 & ~r_cs_block;
    assign w_cs_rise  = r_cs_s2 & ~r_cs_s3;
    assign w_word     = {r_shift[14:0], r_mosi_s2};
    assign w_byte     = w_word[7:0];
    assign w_shift_en = w_sck_rise & ~w_cs_rise & (r_state == S_CMD || r_state == S_PIX);
    assign w_cmd_done = w_shift_en & (r_state == S_CMD) & (r_bit_cnt == 4'd7);
    assign w_pix_done = w_shift_en & (r_state == S_PIX) & (r_bit_cnt == 4'd15);
    assign o_pixel_data   = r_pixel_data;
    assign o_pixel_en_pls = r_pixel_en;
    assign o_vsync_pls    = r_vsync;
    assign o_pixel_cnt    = r_pixel_cnt;
    assign o_overrun      = r_overrun;
    assign o_busy         = (r_state != S_IDLE);
    // Two-flop synchronisers plus edge-detect stage; block CS until the pins have flushed through after reset and CS is seen high
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            {r_sck_s1, r_sck_s2, r_sck_s3} <= 3'b000;
            {r_cs_s1, r_cs_s2, r_cs_s3}    <= 3'b111;
            {r_mosi_s1, r_mosi_s2}         <= 2'b00;
            r_sync_vld                     <= 2'b00;
            r_cs_block                     <= 1'b1;
        end else begin
            {r_sck_s1, r_sck_s2, r_sck_s3} <= {i_spi_clk, r_sck_s1, r_sck_s2};
            {r_cs_s1, r_cs_s2, r_cs_s3}    <= {i_spi_cs, r_cs_s1, r_cs_s2};
            {r_mosi_s1, r_mosi_s2}         <= {i_spi_mosi, r_mosi_s1};
            r_sync_vld                     <= {r_sync_vld[0], 1'b1};
            r_cs_block                     <= r_cs_block & ~(r_sync_vld[1] & r_cs_s2);
        end
    end
    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_nxt_state;
    end
    // Next state: CS deassertion always wins, the command byte selects pixel reception or discard
    always_comb begin
        w_nxt_state = r_state;
        if (w_cs_rise)
            w_nxt_state = S_IDLE;
        else if (r_state == S_IDLE && w_cs_fall)
            w_nxt_state = S_CMD;
        else if (w_cmd_done)
            w_nxt_state = (w_byte == CMD_FRAME || w_byte == CMD_CONT) ? S_PIX : S_DISCARD;
    end
    // Shift register, bit counter, pixel/vsync pulses and frame accounting
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_pixel_data <= '0;
            r_pixel_en   <= 1'b0;
            r_vsync      <= 1'b0;
            r_pixel_cnt  <= '0;
            r_overrun    <= 1'b0;
        end else begin
            r_pixel_en <= 1'b0;
            r_vsync    <= 1'b0;
            if (r_state == S_IDLE && w_cs_fall) begin
                r_shift   <= '0;
                r_bit_cnt <= '0;
            end else if (w_shift_en) begin
                r_shift   <= w_word;
                r_bit_cnt <= w_cmd_done ? 4'd0 : r_bit_cnt + 4'd1;
            end
            if (w_cmd_done && w_byte == CMD_FRAME) begin
                r_vsync     <= 1'b1;
                r_pixel_cnt <= '0;
                r_overrun   <= 1'b0;
            end
            if (w_pix_done) begin
                if (r_pixel_cnt == LP_MAX) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_pixel_data <= w_word;
                    r_pixel_en   <= 1'b1;
                    r_pixel_cnt  <= r_pixel_cnt + 17'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_pixel_rx.sv
// tb_spi_pixel_rx: randomized SPI transactions checked against a transaction-level pixel model
module tb_spi_pixel_rx;
    localparam int FP = 4;
    logic        clk = 1'b0, rst = 1'b1, sck = 1'b0, cs = 1'b1, mosi = 1'b0;
    logic [15:0] pix_data;
    logic        pix_en, vsync, overrun, busy;
    logic [16:0] pix_cnt;
    int          n_tests = 0, n_fail = 0;
    logic [15:0] obs_q[$], exp_q[$];
    int          obs_vs = 0, exp_vs = 0, overlap = 0;
    int          m_cnt = 0;
    logic        m_ovr = 1'b0;
    logic [15:0] m_last = 16'h0;
    logic [15:0] words[8];

    spi_pixel_rx #(.FRAME_PIXELS(FP)) dut (
        .i_clk(clk), .i_rst(rst), .i_spi_clk(sck), .i_spi_cs(cs), .i_spi_mosi(mosi),
        .o_pixel_data(pix_data), .o_pixel_en_pls(pix_en), .o_vsync_pls(vsync),
        .o_pixel_cnt(pix_cnt), .o_overrun(overrun), .o_busy(busy)
    );

    always #5 clk = ~clk;

    // Record every pulse seen by the downstream consumer
    always @(negedge clk) begin
        if (pix_en) obs_q.push_back(pix_data);
        if (vsync) obs_vs++;
        if (pix_en && vsync) overlap++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_bits(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = v[i];
            #40 sck = 1'b1;
            #40 sck = 1'b0;
        end
    endtask

    task automatic verify(input string tag);
        chk({tag, "_npix"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0)
            chk({tag, "_data"}, obs_q.pop_front(), exp_q.pop_front());
        obs_q.delete();
        exp_q.delete();
        chk({tag, "_vsync"}, obs_vs, exp_vs);
        chk({tag, "_cnt"}, pix_cnt, m_cnt);
        chk({tag, "_ovr"}, overrun, m_ovr);
        chk({tag, "_hold"}, pix_data, m_last);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // One CS-framed transaction: command byte, nw full words, then a truncated tail
    task automatic txn(input string tag, input logic [7:0] cmd, input int nw, input int extra);
        cs = 1'b0;
        #40;
        send_bits({8'h00, cmd}, 8);
        for (int i = 0; i < nw; i++) send_bits(words[i], 16);
        if (extra > 0) send_bits(16'($urandom), extra);
        #40 cs = 1'b1;
        if (cmd == 8'h01) begin
            exp_vs++;
            m_cnt = 0;
            m_ovr = 1'b0;
        end
        if (cmd == 8'h01 || cmd == 8'h02)
            for (int i = 0; i < nw; i++) begin
                if (m_cnt == FP) m_ovr = 1'b1;
                else begin
                    exp_q.push_back(words[i]);
                    m_last = words[i];
                    m_cnt++;
                end
            end
        #200;
        verify(tag);
    endtask

    initial begin
        #50 rst = 1'b0;
        #100;
        chk("rst_data", pix_data, 0);
        chk("rst_cnt", pix_cnt, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pulses", obs_q.size() + obs_vs, 0);

        words[0] = 16'hF800;
        txn("frame", 8'h01, 1, 0);
        words[0] = 16'h07E0; words[1] = 16'h001F;
        txn("cont", 8'h02, 2, 0);
        words[0] = 16'($urandom); words[1] = 16'($urandom);
        txn("badcmd", 8'h55, 2, 0);
        txn("partial", 8'h02, 0, 9);
        words[0] = 16'h1234;
        txn("after_part", 8'h02, 1, 0);
        for (int i = 0; i < 6; i++) words[i] = 16'($urandom);
        txn("overrun", 8'h01, 6, 0);
        txn("clr_ovr", 8'h01, 0, 0);

        for (int t = 0; t < 10; t++) begin
            logic [7:0] cmd;
            int sel;
            sel = $urandom_range(0, 3);
            cmd = (sel == 0) ? 8'h01 : (sel == 3) ? (8'h80 | 8'($urandom)) : 8'h02;
            for (int i = 0; i < 8; i++) words[i] = 16'($urandom);
            txn("rand", cmd, $urandom_range(0, 6), $urandom_range(0, 15));
        end

        cs = 1'b0;
        #40;
        send_bits(16'h0002, 8);
        send_bits(16'hABCD, 10);
        rst = 1'b1;
        #20 rst = 1'b0;
        #20;
        m_cnt = 0;
        m_ovr = 1'b0;
        m_last = 16'h0;
        chk("midrst_data", pix_data, 0);
        chk("midrst_cnt", pix_cnt, 0);
        chk("midrst_ovr", overrun, 0);
        chk("midrst_busy", busy, 0);
        send_bits(16'hABCD, 6);
        send_bits(16'h5555, 16);
        #200;
        verify("midrst_ign");
        cs = 1'b1;
        #200;
        words[0] = 16'h0BAD;
        txn("post_rst", 8'h02, 1, 0);

        chk("vs_en_overlap", overlap, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
